// File: rtl/mips_pkg.sv
// Purpose: shared MIPS32 decode definitions: instruction field positions,
//          opcode constants, control bundle and the opcode decode table.
package mips_pkg;

  localparam int unsigned NB_OPCODE = 6;
  localparam int unsigned NB_FUNCT  = 6;
  localparam int unsigned NB_SHAMT  = 5;
  localparam int unsigned NB_IMM    = 16;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  localparam int unsigned RA_REG = 31;

  localparam logic [NB_OPCODE-1:0] OP_RTYPE = 6'h00;
  localparam logic [NB_OPCODE-1:0] OP_J     = 6'h02;
  localparam logic [NB_OPCODE-1:0] OP_JAL   = 6'h03;
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = 6'h04;
  localparam logic [NB_OPCODE-1:0] OP_BNE   = 6'h05;
  localparam logic [NB_OPCODE-1:0] OP_ADDI  = 6'h08;
  localparam logic [NB_OPCODE-1:0] OP_SLTI  = 6'h0A;
  localparam logic [NB_OPCODE-1:0] OP_ANDI  = 6'h0C;
  localparam logic [NB_OPCODE-1:0] OP_ORI   = 6'h0D;
  localparam logic [NB_OPCODE-1:0] OP_XORI  = 6'h0E;
  localparam logic [NB_OPCODE-1:0] OP_LUI   = 6'h0F;
  localparam logic [NB_OPCODE-1:0] OP_LW    = 6'h23;
  localparam logic [NB_OPCODE-1:0] OP_SW    = 6'h2B;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dst_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    dst_sel_e dst_sel;
    logic     zero_ext;
  } decode_t;

  // Opcode -> control bundle; unknown opcodes decode to all-zero control
  function automatic decode_t decode_opcode(input logic [NB_OPCODE-1:0] opcode);
    decode_t d;
    d = '0;
    d.dst_sel = DST_RT;
    case (opcode)
      OP_RTYPE: begin
        d.ctrl.reg_write = 1'b1;
        d.dst_sel        = DST_RD;
      end
      OP_ADDI, OP_SLTI, OP_LUI: d.ctrl.reg_write = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.ctrl.reg_write = 1'b1;
        d.zero_ext       = 1'b1;
      end
      OP_LW: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
      end
      OP_SW:          d.ctrl.mem_write = 1'b1;
      OP_BEQ, OP_BNE: d.ctrl.branch    = 1'b1;
      OP_J:           d.ctrl.jump      = 1'b1;
      OP_JAL: begin
        d.ctrl.jump      = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.dst_sel        = DST_RA;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Purpose: N_REGS x NB_DATA register file, register 0 hard-wired to zero.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears contents)
//   wr_en/addr/data     synchronous write port
//   rd_addr_1/2         asynchronous read addresses
//   rd_data_1/2         read data, bypassed from the write port on a same-cycle hit
module reg_file #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned N_REGS      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [NB_REG_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0]     wr_data,
  input  logic [NB_REG_ADDR-1:0] rd_addr_1,
  input  logic [NB_REG_ADDR-1:0] rd_addr_2,
  output logic [NB_DATA-1:0]     rd_data_1,
  output logic [NB_DATA-1:0]     rd_data_2
);

  logic [NB_DATA-1:0] regs [N_REGS];

  // Storage; writes to register 0 or beyond N_REGS are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_REGS); i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0) && (32'(wr_addr) < N_REGS)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port 1 with write-back bypass
  always_comb begin
    rd_data_1 = '0;
    if ((rd_addr_1 != '0) && (32'(rd_addr_1) < N_REGS)) begin
      if (wr_en && (wr_addr == rd_addr_1)) rd_data_1 = wr_data;
      else                                 rd_data_1 = regs[rd_addr_1];
    end
  end

  // Read port 2 with write-back bypass
  always_comb begin
    rd_data_2 = '0;
    if ((rd_addr_2 != '0) && (32'(rd_addr_2) < N_REGS)) begin
      if (wr_en && (wr_addr == rd_addr_2)) rd_data_2 = wr_data;
      else                                 rd_data_2 = regs[rd_addr_2];
    end
  end

endmodule

// File: rtl/id_pipeline_stage.sv
// Purpose: MIPS instruction-decode stage: register file read with write-back
//          bypass, opcode decode, load-use hazard detection and the ID/EX
//          pipeline register with flush / external stall / bubble insertion.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_valid, i_instruc, i_PC      IF/ID contents (PC is PC+4)
//   i_wb_en/addr/data             write-back port into the register file
//   i_ex_mem_read, i_ex_rt        load currently in EX and its destination
//   i_flush, i_stall_ext          downstream kill / hold requests
//   o_stall                       combinational hold for PC and IF/ID
//   o_*                           registered ID/EX contents
module id_pipeline_stage
  import mips_pkg::*;
#(
  parameter int unsigned NB_INSTRUC  = 32,
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_PC       = 32,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned N_REGS      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [NB_INSTRUC-1:0]  i_instruc,
  input  logic [NB_PC-1:0]       i_PC,
  input  logic                   i_wb_en,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]     i_wb_data,
  input  logic                   i_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0] i_ex_rt,
  input  logic                   i_flush,
  input  logic                   i_stall_ext,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [NB_PC-1:0]       o_PC,
  output logic [NB_DATA-1:0]     o_read_data_1,
  output logic [NB_DATA-1:0]     o_read_data_2,
  output logic [NB_DATA-1:0]     o_imm_ext,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_dst_reg,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [NB_FUNCT-1:0]    o_funct,
  output logic [NB_SHAMT-1:0]    o_shamt,
  output logic                   o_reg_write,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_branch,
  output logic                   o_jump,
  output logic [NB_PC-1:0]       o_branch_target
);

  logic [NB_OPCODE-1:0]   opcode;
  logic [NB_FUNCT-1:0]    funct;
  logic [NB_SHAMT-1:0]    shamt;
  logic [NB_IMM-1:0]      imm;
  logic [NB_REG_ADDR-1:0] rs;
  logic [NB_REG_ADDR-1:0] rt;
  logic [NB_REG_ADDR-1:0] rd;
  logic [NB_DATA-1:0]     rf_data_1;
  logic [NB_DATA-1:0]     rf_data_2;
  logic [NB_DATA-1:0]     imm_ext;
  logic signed [NB_IMM+1:0] br_offset;
  logic [NB_PC-1:0]       branch_target;
  logic [NB_REG_ADDR-1:0] dst_reg;
  decode_t                dec;
  logic                   load_use;
  ctrl_t                  ctrl_q;

  // Instruction field extraction
  assign opcode = i_instruc[OPCODE_MSB:OPCODE_LSB];
  assign funct  = i_instruc[FUNCT_MSB:FUNCT_LSB];
  assign shamt  = i_instruc[SHAMT_MSB:SHAMT_LSB];
  assign imm    = i_instruc[IMM_MSB:IMM_LSB];
  assign rs     = NB_REG_ADDR'(i_instruc[RS_MSB:RS_LSB]);
  assign rt     = NB_REG_ADDR'(i_instruc[RT_MSB:RT_LSB]);
  assign rd     = NB_REG_ADDR'(i_instruc[RD_MSB:RD_LSB]);

  reg_file #(
    .NB_DATA     (NB_DATA),
    .NB_REG_ADDR (NB_REG_ADDR),
    .N_REGS      (N_REGS)
  ) u_reg_file (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (i_wb_en),
    .wr_addr   (i_wb_addr),
    .wr_data   (i_wb_data),
    .rd_addr_1 (rs),
    .rd_addr_2 (rt),
    .rd_data_1 (rf_data_1),
    .rd_data_2 (rf_data_2)
  );

  // Control decode and destination select
  always_comb begin
    dec     = decode_opcode(opcode);
    dst_reg = rt;
    case (dec.dst_sel)
      DST_RD:  dst_reg = rd;
      DST_RA:  dst_reg = NB_REG_ADDR'(RA_REG);
      default: dst_reg = rt;
    endcase
  end

  // Immediate extension; the branch offset is the word-scaled sign-extended imm
  assign imm_ext       = dec.zero_ext ? NB_DATA'(imm) : NB_DATA'($signed(imm));
  assign br_offset     = $signed({imm, 2'b00});
  assign branch_target = i_PC + NB_PC'(br_offset);

  // rt is compared for every opcode, even those that never read it
  assign load_use = i_valid & i_ex_mem_read & (i_ex_rt != '0) &
                    ((i_ex_rt == rs) | (i_ex_rt == rt));

  // A flush kills the instruction in ID, so it cannot also ask IF to hold
  assign o_stall = i_stall_ext | (load_use & ~i_flush);

  // ID/EX register: flush > external stall > load-use bubble > capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid         <= 1'b0;
      ctrl_q          <= '0;
      o_PC            <= '0;
      o_read_data_1   <= '0;
      o_read_data_2   <= '0;
      o_imm_ext       <= '0;
      o_rs            <= '0;
      o_rt            <= '0;
      o_dst_reg       <= '0;
      o_opcode        <= '0;
      o_funct         <= '0;
      o_shamt         <= '0;
      o_branch_target <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      ctrl_q  <= '0;
    end else if (!i_stall_ext) begin
      if (load_use) begin
        o_valid <= 1'b0;
        ctrl_q  <= '0;
      end else begin
        o_valid         <= i_valid;
        ctrl_q          <= i_valid ? dec.ctrl : '0;
        o_PC            <= i_PC;
        o_read_data_1   <= rf_data_1;
        o_read_data_2   <= rf_data_2;
        o_imm_ext       <= imm_ext;
        o_rs            <= rs;
        o_rt            <= rt;
        o_dst_reg       <= dst_reg;
        o_opcode        <= opcode;
        o_funct         <= funct;
        o_shamt         <= shamt;
        o_branch_target <= branch_target;
      end
    end
  end

  assign o_reg_write = ctrl_q.reg_write;
  assign o_mem_read  = ctrl_q.mem_read;
  assign o_mem_write = ctrl_q.mem_write;
  assign o_branch    = ctrl_q.branch;
  assign o_jump      = ctrl_q.jump;

endmodule

// File: tb/tb_id_pipeline_stage.sv
// Purpose: self-checking bench for id_pipeline_stage: directed scenarios from
//          the decode/hazard rules plus a randomized run against a
//          cycle-level reference model kept in the bench.
module tb_id_pipeline_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_instruc;
  logic [31:0] i_PC;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        i_flush;
  logic        i_stall_ext;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_PC;
  logic [31:0] o_read_data_1;
  logic [31:0] o_read_data_2;
  logic [31:0] o_imm_ext;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_dst_reg;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;
  logic [4:0]  o_shamt;
  logic        o_reg_write;
  logic        o_mem_read;
  logic        o_mem_write;
  logic        o_branch;
  logic        o_jump;
  logic [31:0] o_branch_target;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  id_pipeline_stage dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .i_instruc       (i_instruc),
    .i_PC            (i_PC),
    .i_wb_en         (i_wb_en),
    .i_wb_addr       (i_wb_addr),
    .i_wb_data       (i_wb_data),
    .i_ex_mem_read   (i_ex_mem_read),
    .i_ex_rt         (i_ex_rt),
    .i_flush         (i_flush),
    .i_stall_ext     (i_stall_ext),
    .o_stall         (o_stall),
    .o_valid         (o_valid),
    .o_PC            (o_PC),
    .o_read_data_1   (o_read_data_1),
    .o_read_data_2   (o_read_data_2),
    .o_imm_ext       (o_imm_ext),
    .o_rs            (o_rs),
    .o_rt            (o_rt),
    .o_dst_reg       (o_dst_reg),
    .o_opcode        (o_opcode),
    .o_funct         (o_funct),
    .o_shamt         (o_shamt),
    .o_reg_write     (o_reg_write),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (o_mem_write),
    .o_branch        (o_branch),
    .o_jump          (o_jump),
    .o_branch_target (o_branch_target)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        valid;
    logic [4:0]  ctrl;   // {reg_write, mem_read, mem_write, branch, jump}
    logic [31:0] pc, rd1, rd2, imm, tgt;
    logic [4:0]  rs, rt, dst, shamt;
    logic [5:0]  op, funct;
  } exp_t;

  logic [31:0] mregs [32];
  exp_t        ex;

  function automatic logic [4:0] m_ctrl(input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h0A, 6'h0F, 6'h0C, 6'h0D, 6'h0E: return 5'b10000;
      6'h23:        return 5'b11000;
      6'h2B:        return 5'b00100;
      6'h04, 6'h05: return 5'b00010;
      6'h02:        return 5'b00001;
      6'h03:        return 5'b10001;
      default:      return 5'b00000;
    endcase
  endfunction

  // 0: immediate unspecified, 1: sign-extended, 2: zero-extended
  function automatic int m_imm_kind(input logic [5:0] op);
    case (op)
      6'h08, 6'h0A, 6'h0F, 6'h23, 6'h2B: return 1;
      6'h0C, 6'h0D, 6'h0E:               return 2;
      default:                           return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_wb_en && (i_wb_addr == a)) return i_wb_data;
    return mregs[a];
  endfunction

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_valid = 1'b0; i_instruc = 32'd0; i_PC = 32'd0;
    i_wb_en = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
    i_ex_mem_read = 1'b0; i_ex_rt = 5'd0; i_flush = 1'b0; i_stall_ext = 1'b0;
  endtask

  task automatic drive_instr(input logic [31:0] ins, input logic [31:0] pc);
    i_valid = 1'b1; i_instruc = ins; i_PC = pc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    i_rst = 1'b1;
    tick(); tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if ({o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump}); end
    checks++; if ({o_PC, o_read_data_1, o_read_data_2, o_imm_ext, o_branch_target} !== 160'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {o_PC, o_read_data_1, o_read_data_2, o_imm_ext, o_branch_target}); end
    checks++; if ({o_rs, o_rt, o_dst_reg, o_opcode, o_funct, o_shamt} !== 32'd0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {o_rs, o_rt, o_dst_reg, o_opcode, o_funct, o_shamt}); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_imm_ext;
    drive_instr(32'h2001FFFB, 32'h0000_0004);   // ADDI $1,$0,-5
    tick();
    checks++; if (o_imm_ext !== 32'hFFFFFFFB) begin errors++; $display("FAIL addi_imm got=%h exp=fffffffb", o_imm_ext); end
    checks++; if (o_dst_reg !== 5'd1) begin errors++; $display("FAIL addi_dst got=%0d exp=1", o_dst_reg); end
    checks++; if ({o_valid, o_reg_write, o_opcode} !== {1'b1, 1'b1, 6'h08}) begin errors++; $display("FAIL addi_ctrl got=%b/%b/%h exp=1/1/08", o_valid, o_reg_write, o_opcode); end
    checks++; if (o_PC !== 32'h4) begin errors++; $display("FAIL addi_pc got=%h exp=00000004", o_PC); end
    drive_instr(32'h34028000, 32'h0000_0008);   // ORI $2,$0,0x8000
    tick();
    checks++; if (o_imm_ext !== 32'h00008000) begin errors++; $display("FAIL ori_imm got=%h exp=00008000", o_imm_ext); end
    checks++; if ({o_dst_reg, o_reg_write} !== {5'd2, 1'b1}) begin errors++; $display("FAIL ori_dst got=%0d/%b exp=2/1", o_dst_reg, o_reg_write); end
    drive_instr(32'h8C088004, 32'h0000_000C);   // LW $8,0x8004($0)
    tick();
    checks++; if ({o_reg_write, o_mem_read, o_mem_write, o_dst_reg} !== {3'b110, 5'd8}) begin errors++; $display("FAIL lw_ctrl got=%b%b%b/%0d exp=110/8", o_reg_write, o_mem_read, o_mem_write, o_dst_reg); end
    checks++; if (o_imm_ext !== 32'hFFFF8004) begin errors++; $display("FAIL lw_imm got=%h exp=ffff8004", o_imm_ext); end
    idle_inputs();
  endtask

  task automatic test_bypass;
    drive_instr(32'h00632020, 32'h0000_0010);   // ADD $4,$3,$3
    i_wb_en = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'hDEADBEEF;
    tick();
    checks++; if ({o_read_data_1, o_read_data_2} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin errors++; $display("FAIL bypass_data got=%h/%h exp=deadbeef", o_read_data_1, o_read_data_2); end
    checks++; if ({o_dst_reg, o_rs, o_rt} !== {5'd4, 5'd3, 5'd3}) begin errors++; $display("FAIL add_regs got=%0d/%0d/%0d exp=4/3/3", o_dst_reg, o_rs, o_rt); end
    i_wb_en = 1'b0;
    tick();
    checks++; if (o_read_data_1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_stored got=%h exp=deadbeef", o_read_data_1); end
    idle_inputs();
  endtask

  task automatic test_load_use;
    drive_instr(32'h00A73022, 32'h0000_0020);   // SUB $6,$5,$7
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd5;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", o_stall); end
    tick();
    checks++; if ({o_valid, o_reg_write} !== 2'b00) begin errors++; $display("FAIL lu_bubble got=%b%b exp=00", o_valid, o_reg_write); end
    i_ex_mem_read = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", o_stall); end
    tick();
    checks++; if ({o_valid, o_reg_write, o_dst_reg, o_rs, o_rt} !== {2'b11, 5'd6, 5'd5, 5'd7}) begin errors++; $display("FAIL lu_capture got=%b%b/%0d/%0d/%0d exp=11/6/5/7", o_valid, o_reg_write, o_dst_reg, o_rs, o_rt); end
    // Same hazard with flush: no stall, bubble
    i_ex_mem_read = 1'b1; i_flush = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", o_stall); end
    tick();
    checks++; if ({o_valid, o_reg_write} !== 2'b00) begin errors++; $display("FAIL flush_bubble got=%b%b exp=00", o_valid, o_reg_write); end
    idle_inputs();
  endtask

  task automatic test_stall_ext;
    drive_instr(32'h2001FFFB, 32'h0000_0040);   // ADDI
    tick();
    drive_instr(32'h00A73022, 32'h0000_0044);   // SUB with hazard on $5
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd5; i_stall_ext = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL stx_stall got=%b exp=1", o_stall); end
    tick();
    checks++; if ({o_valid, o_opcode, o_PC} !== {1'b1, 6'h08, 32'h40}) begin errors++; $display("FAIL stx_hold got=%b/%h/%h exp=1/08/00000040", o_valid, o_opcode, o_PC); end
    // Reset arrives mid-cycle while stalled
    #2 i_rst = 1'b1;
    #1;
    checks++; if ({o_valid, o_reg_write, o_PC} !== 34'd0) begin errors++; $display("FAIL rst_mid_clear got=%b%b/%h exp=00/0", o_valid, o_reg_write, o_PC); end
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got=%b exp=1", o_stall); end
    tick();
    i_rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_zero;
    drive_instr(32'h1022FFFF, 32'h0000_0100);   // BEQ $1,$2,-1
    tick();
    checks++; if (o_branch_target !== 32'h000000FC) begin errors++; $display("FAIL beq_target got=%h exp=000000fc", o_branch_target); end
    checks++; if ({o_branch, o_reg_write, o_jump} !== 3'b100) begin errors++; $display("FAIL beq_ctrl got=%b exp=100", {o_branch, o_reg_write, o_jump}); end
    drive_instr(32'h14000002, 32'hFFFF_FFFC);   // BNE wrap forward
    tick();
    checks++; if (o_branch_target !== 32'h00000004) begin errors++; $display("FAIL bne_wrap got=%h exp=00000004", o_branch_target); end
    drive_instr(32'h0C000010, 32'h0000_0200);   // JAL
    tick();
    checks++; if ({o_jump, o_reg_write, o_dst_reg} !== {2'b11, 5'd31}) begin errors++; $display("FAIL jal got=%b%b/%0d exp=11/31", o_jump, o_reg_write, o_dst_reg); end
    drive_instr(32'hFC000000, 32'h0000_0204);   // unknown opcode 0x3F
    tick();
    checks++; if ({o_valid, o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump} !== 6'b100000) begin errors++; $display("FAIL unknown_op got=%b exp=100000", {o_valid, o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump}); end
    // Write to $0 must be ignored, bypass included
    drive_instr(32'h00000820, 32'h0000_0208);   // ADD $1,$0,$0
    i_wb_en = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h12345678;
    tick();
    checks++; if ({o_read_data_1, o_read_data_2} !== 64'd0) begin errors++; $display("FAIL r0_bypass got=%h/%h exp=0", o_read_data_1, o_read_data_2); end
    i_wb_en = 1'b0;
    tick();
    checks++; if ({o_read_data_1, o_read_data_2} !== 64'd0) begin errors++; $display("FAIL r0_read got=%h/%h exp=0", o_read_data_1, o_read_data_2); end
    idle_inputs();
  endtask

  task automatic test_random;
    logic [5:0]  ops [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h1C};
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        lu, e_stall;
    int          kind;
    idle_inputs();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
    ex = '{valid: 1'b0, ctrl: 5'd0, pc: 32'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0,
           tgt: 32'd0, rs: 5'd0, rt: 5'd0, dst: 5'd0, shamt: 5'd0, op: 6'd0, funct: 6'd0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      op  = ops[$urandom_range(0, 14)];
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      i_valid       = ($urandom_range(0, 9) < 8);
      i_instruc     = {op, rs, rt, imm};
      i_PC          = $urandom;
      i_wb_en       = 1'($urandom_range(0, 1));
      i_wb_addr     = 5'($urandom_range(0, 7));
      i_wb_data     = $urandom;
      i_ex_mem_read = ($urandom_range(0, 9) < 3);
      i_ex_rt       = 5'($urandom_range(0, 7));
      i_flush       = ($urandom_range(0, 9) == 0);
      i_stall_ext   = ($urandom_range(0, 9) < 2);

      lu      = i_valid && i_ex_mem_read && (i_ex_rt != 0) && ((i_ex_rt == rs) || (i_ex_rt == rt));
      e_stall = i_stall_ext || (lu && !i_flush);
      #1;
      checks++; if (o_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, o_stall, e_stall); end

      if (i_flush || (!i_stall_ext && lu)) begin
        ex.valid = 1'b0;
        ex.ctrl  = 5'd0;
      end else if (!i_stall_ext) begin
        ex.valid = i_valid;
        ex.ctrl  = i_valid ? m_ctrl(op) : 5'd0;
        ex.pc    = i_PC;
        ex.rd1   = m_read(rs);
        ex.rd2   = m_read(rt);
        ex.rs    = rs;
        ex.rt    = rt;
        ex.op    = op;
        ex.funct = imm[5:0];
        ex.shamt = imm[10:6];
        kind     = m_imm_kind(op);
        ex.imm   = (kind == 2) ? {16'd0, imm} : {{16{imm[15]}}, imm};
        ex.tgt   = i_PC + {{14{imm[15]}}, imm, 2'b00};
        ex.dst   = (op == 6'h00) ? imm[15:11] : ((op == 6'h03) ? 5'd31 : rt);
      end
      if (i_wb_en && (i_wb_addr != 0)) mregs[i_wb_addr] = i_wb_data;
      tick();

      checks++; if (o_valid !== ex.valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, o_valid, ex.valid); end
      checks++; if ({o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump} !== ex.ctrl) begin errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump}, ex.ctrl); end
      if (ex.valid) begin
        checks++; if ({o_read_data_1, o_read_data_2} !== {ex.rd1, ex.rd2}) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", cyc, o_read_data_1, o_read_data_2, ex.rd1, ex.rd2); end
        checks++; if ({o_PC, o_branch_target} !== {ex.pc, ex.tgt}) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h/%h exp=%h/%h", cyc, o_PC, o_branch_target, ex.pc, ex.tgt); end
        checks++; if ({o_rs, o_rt, o_opcode, o_funct, o_shamt} !== {ex.rs, ex.rt, ex.op, ex.funct, ex.shamt}) begin errors++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", cyc, {o_rs, o_rt, o_opcode, o_funct, o_shamt}, {ex.rs, ex.rt, ex.op, ex.funct, ex.shamt}); end
        if (ex.ctrl[4]) begin
          checks++; if (o_dst_reg !== ex.dst) begin errors++; $display("FAIL rnd_dst cyc=%0d got=%0d exp=%0d", cyc, o_dst_reg, ex.dst); end
        end
        if (m_imm_kind(ex.op) != 0) begin
          checks++; if (o_imm_ext !== ex.imm) begin errors++; $display("FAIL rnd_imm cyc=%0d got=%h exp=%h", cyc, o_imm_ext, ex.imm); end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    i_rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_imm_ext();
    test_bypass();
    test_load_use();
    test_stall_ext();
    test_branch_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_pipeline_stage.md
# id_pipeline_stage

Parametrised MIPS instruction-decode stage with an integrated register file, write-back bypass, load-use hazard detection and a registered ID/EX pipeline boundary with stall and flush. It sits between the IF/ID register and the execute stage. It consumes the fetched instruction and PC+4, and presents fully decoded operands and control to EX one cycle later.

## Interface
- NB_INSTRUC, 32, instruction width; MIPS32 field positions fixed (opcode 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0)
- NB_DATA, 32, register/operand width, must be >= 16
- NB_PC, 32, program-counter width
- NB_REG_ADDR, 5, register address width
- N_REGS, 32, register count (<= 2**NB_REG_ADDR)
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_instruc  in  NB_INSTRUC  instruction from IF/ID
- i_PC  in  NB_PC  PC+4 of that instruction
- i_wb_en / i_wb_addr / i_wb_data  in  1 / NB_REG_ADDR / NB_DATA  write-back port
- i_ex_mem_read  in  1  instruction now in EX is a load
- i_ex_rt  in  NB_REG_ADDR  destination of that load
- i_flush  in  1  taken branch/jump resolved downstream; kill instruction in ID
- i_stall_ext  in  1  downstream stall; hold ID/EX
- o_stall  out  1  hold PC and IF/ID
- o_valid  out  1  ID/EX holds a valid instruction
- o_PC  out  NB_PC  registered PC+4
- o_read_data_1, o_read_data_2  out  NB_DATA  registered rs/rt values
- o_imm_ext  out  NB_DATA  registered extended immediate
- o_rs, o_rt, o_dst_reg  out  NB_REG_ADDR  registered source/destination indices
- o_opcode, o_funct, o_shamt  out  6, 6, 5  registered fields
- o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump  out  1 each  registered control
- o_branch_target  out  NB_PC  registered i_PC + (sext(imm) << 2), truncated to NB_PC

## Operation
- Register file: N_REGS x NB_DATA; reg 0 reads 0; writes to 0 ignored; written on clock edge when i_wb_en.
- Combinational read with bypass: if i_wb_en, i_wb_addr == rs and rs != 0, data_1 = i_wb_data (same for rt).
- Decode table:
  - R-type 0x00: reg_write, dst = rd
  - ADDI 0x08, SLTI 0x0A, LUI 0x0F: reg_write, dst = rt, sign-extend
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: reg_write, dst = rt, zero-extend
  - LW 0x23: mem_read, reg_write, dst = rt, sign-extend
  - SW 0x2B: mem_write, sign-extend
  - BEQ 0x04, BNE 0x05: branch
  - J 0x02: jump
  - JAL 0x03: jump, reg_write, dst = 31
  - Unknown opcode: all controls 0.
- Load-use hazard: `load_use = i_valid & i_ex_mem_read & (i_ex_rt != 0) & (i_ex_rt == rs | i_ex_rt == rt)`. rt is compared for every opcode; the stall is deliberately conservative.
- ID/EX update priority, highest first:
  1. Reset: all outputs 0.
  2. i_flush: o_valid and all controls cleared, other fields don't-care.
  3. i_stall_ext: hold everything.
  4. load_use: bubble (o_valid = 0, controls 0).
  5. Otherwise: capture decode; o_valid = i_valid; controls forced 0 if !i_valid.
- `o_stall = i_stall_ext | (load_use & ~i_flush)`, combinational.

## Timing
- Reset (asynchronous): every output register = 0; register file contents cleared to 0.
- Latency: instruction present in IF/ID at edge n appears on outputs after edge n+1.
- Write-back and read of the same register in the same cycle: the read returns the new value (bypass). There is no read-after-write gap.
- Load-use: o_stall is high for exactly one cycle when EX holds the load. Next cycle the load has left EX, the hazard clears and the instruction is captured.
- i_flush and load_use together: flush wins; o_stall is low.
- i_stall_ext and load_use together: ID/EX holds; o_stall is high.
- Reset asserted mid-stall: outputs are cleared immediately and o_stall follows the combinational inputs.
- Branch-target add wraps modulo 2**NB_PC.

## Structure
- Shared package `mips_pkg`: opcode constants (OP_RTYPE, OP_LW, ...), field-position constants, control-bundle typedef.
- One sub-module, `reg_file` (parameters NB_DATA, NB_REG_ADDR, N_REGS; 2 async read ports, 1 sync write port, internal bypass).
- Decode logic, hazard detection and ID/EX register live in the top.

## Test plan
- Reset, then ADDI $1,$0,-5 (0x2001FFFB) with i_valid: next cycle o_imm_ext = 0xFFFFFFFB, o_dst_reg = 1, o_reg_write = 1.
- ORI $2,$0,0x8000: o_imm_ext = 0x00008000 (zero-extended).
- Write $3 = 0xDEADBEEF via WB while decoding ADD $4,$3,$3: o_read_data_1 and o_read_data_2 = 0xDEADBEEF in the same capture.
- i_ex_mem_read = 1, i_ex_rt = 5 while decoding SUB $6,$5,$7: o_stall = 1 for one cycle, a bubble is inserted (o_valid = 0), then the instruction is captured.
- Same hazard with i_flush = 1: o_stall = 0, o_valid = 0 next cycle.
- BEQ at PC+4 = 0x100 with imm = 0xFFFF: o_branch_target = 0xFC, o_branch = 1. Write to $0 is ignored: reading $0 afterwards gives 0.
